// File: rtl/param_dual_port_ram.sv
// True dual-port synchronous RAM with registered read data.
// The sweep state machine zeroes every word after reset when CLEAR_ON_RESET=1.
// Both ports are blocked while the sweep runs.
// When both ports write the same address in one cycle, port A's data is
// stored and a one-cycle collision pulse is raised.
module param_dual_port_ram #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  input  logic                  en_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_b,
  input  logic                  en_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  busy,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [0:0] RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  acc_a;
  logic                  acc_b;
  logic                  wr_a;
  logic                  wr_b;

  // Read data for a port: on a write by the same port, write-first mode
  // returns the incoming word; otherwise the stored (old) word is returned.
  function automatic logic [DATA_WIDTH-1:0] read_word(
    input logic                  we,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] old
  );
    if (we && (RDW_MODE != 0)) begin
      return wdata;
    end
    return old;
  endfunction

  assign busy  = (state == CLEAR);
  assign acc_a = en_a && !busy;
  assign acc_b = en_b && !busy;
  assign wr_a  = acc_a && we_a;
  assign wr_b  = acc_b && we_b;

  // Sweep controller: the counter walks 0..DEPTH-1 once, then stops without wrapping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      if (clr_cnt == LAST_ADDR) begin
        state <= IDLE;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Storage array: holds its contents through reset.
  // The sweep writes zeros.
  // Port A is written after port B, so A wins on an address conflict.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (busy) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wr_b) begin
          mem[addr_b] <= data_b;
        end
        if (wr_a) begin
          mem[addr_a] <= data_a;
        end
      end
    end
  end

  // Registered read ports and the same-address write-write collision flag.
  // Reads see the pre-edge array, so cross-port reads always get old data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
    end else begin
      if (acc_a) begin
        q_a <= read_word(we_a, data_a, mem[addr_a]);
      end
      if (acc_b) begin
        q_b <= read_word(we_b, data_b, mem[addr_b]);
      end
      collision <= wr_a && wr_b && (addr_a == addr_b);
    end
  end

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Bench for param_dual_port_ram.
// Three instances share one stimulus stream:
//   d0 - read-first, cleared on reset
//   d1 - write-first, cleared on reset
//   d2 - read-first, not cleared on reset
// A word-level reference model tracks all three instances.
// Directed table rows and hand-written sequences cover the corner cases.
module tb_param_dual_port_ram;

  localparam int DEPTH = 64;
  localparam bit [2:0] RDW_P = 3'b010;
  localparam bit [2:0] CLR_P = 3'b011;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] data_a, data_b;
  logic [5:0] addr_a, addr_b;
  logic       we_a, we_b, en_a, en_b;
  logic [7:0] dqa [3];
  logic [7:0] dqb [3];
  logic       dbusy [3];
  logic       dcol [3];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  param_dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(0), .CLEAR_ON_RESET(1)) d0 (
    .clock(clock), .reset_n(reset_n),
    .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .en_a(en_a),
    .data_b(data_b), .addr_b(addr_b), .we_b(we_b), .en_b(en_b),
    .q_a(dqa[0]), .q_b(dqb[0]), .busy(dbusy[0]), .collision(dcol[0]));

  param_dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(1), .CLEAR_ON_RESET(1)) d1 (
    .clock(clock), .reset_n(reset_n),
    .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .en_a(en_a),
    .data_b(data_b), .addr_b(addr_b), .we_b(we_b), .en_b(en_b),
    .q_a(dqa[1]), .q_b(dqb[1]), .busy(dbusy[1]), .collision(dcol[1]));

  param_dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(0), .CLEAR_ON_RESET(0)) d2 (
    .clock(clock), .reset_n(reset_n),
    .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .en_a(en_a),
    .data_b(data_b), .addr_b(addr_b), .we_b(we_b), .en_b(en_b),
    .q_a(dqa[2]), .q_b(dqb[2]), .busy(dbusy[2]), .collision(dcol[2]));

  // Reference model state, one set per instance.
  // The known flags let the checker skip reads of never-written words.
  logic [7:0] mmem   [3][DEPTH];
  bit         mknown [3][DEPTH];
  logic [7:0] mqa [3];
  logic [7:0] mqb [3];
  bit         mqak [3];
  bit         mqbk [3];
  bit         mcol [3];
  int         mbusy_left [3];
  bit         armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance the model by one rising edge, using the inputs held at that edge.
  task automatic model_step();
    logic [7:0] olda, oldb;
    bit         oka, okb;
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        mqa[k] = 8'h00; mqb[k] = 8'h00; mqak[k] = 1'b1; mqbk[k] = 1'b1;
        mcol[k] = 1'b0;
        if (CLR_P[k]) begin
          // The sweep that follows zeroes every word before any access is allowed.
          mbusy_left[k] = DEPTH;
          for (int w = 0; w < DEPTH; w++) begin
            mmem[k][w] = 8'h00;
            mknown[k][w] = 1'b1;
          end
        end else begin
          mbusy_left[k] = 0;
        end
      end else if (mbusy_left[k] > 0) begin
        mbusy_left[k]--;
        mcol[k] = 1'b0;
      end else begin
        olda = mmem[k][addr_a]; oka = mknown[k][addr_a];
        oldb = mmem[k][addr_b]; okb = mknown[k][addr_b];
        if (en_a) begin
          if (we_a && RDW_P[k]) begin
            mqa[k] = data_a; mqak[k] = 1'b1;
          end else begin
            mqa[k] = olda; mqak[k] = oka;
          end
        end
        if (en_b) begin
          if (we_b && RDW_P[k]) begin
            mqb[k] = data_b; mqbk[k] = 1'b1;
          end else begin
            mqb[k] = oldb; mqbk[k] = okb;
          end
        end
        mcol[k] = en_a && we_a && en_b && we_b && (addr_a == addr_b);
        if (en_b && we_b) begin
          mmem[k][addr_b] = data_b; mknown[k][addr_b] = 1'b1;
        end
        if (en_a && we_a) begin
          mmem[k][addr_a] = data_a; mknown[k][addr_a] = 1'b1;
        end
      end
    end
    if (!reset_n) armed = 1'b1;
  endtask

  task automatic compare_all();
    if (!armed) return;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy_d%0d", k), 32'(dbusy[k]), 32'(mbusy_left[k] > 0));
      chk($sformatf("collision_d%0d", k), 32'(dcol[k]), 32'(mcol[k]));
      if (mqak[k]) chk($sformatf("q_a_d%0d", k), 32'(dqa[k]), 32'(mqa[k]));
      if (mqbk[k]) chk($sformatf("q_b_d%0d", k), 32'(dqb[k]), 32'(mqb[k]));
    end
  endtask

  // One clock: model updated at the rising edge, outputs checked at the falling edge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle_ports();
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!dbusy[0]) break;
      n++;
      tick();
    end
    chk(name, 32'(n), 32'd64);
  endtask

  typedef struct {
    bit         en_a, we_a;
    logic [5:0] addr_a;
    logic [7:0] data_a;
    bit         en_b, we_b;
    logic [5:0] addr_b;
    logic [7:0] data_b;
    logic [7:0] qa, qb;
    bit         col;
    logic [7:0] qa_wf;
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{1, 1, 6'd1,  8'h33, 1, 1, 6'd2,  8'h44, 8'h00, 8'h00, 0, 8'h33};
    vt[1] = '{1, 0, 6'd2,  8'h00, 1, 0, 6'd1,  8'h00, 8'h44, 8'h33, 0, 8'h44};
    vt[2] = '{1, 1, 6'd5,  8'hAA, 1, 1, 6'd5,  8'hBB, 8'h00, 8'h00, 1, 8'hAA};
    vt[3] = '{0, 0, 6'd0,  8'h00, 0, 0, 6'd0,  8'h00, 8'h00, 8'h00, 0, 8'hAA};
    vt[4] = '{1, 0, 6'd5,  8'h00, 0, 0, 6'd0,  8'h00, 8'hAA, 8'h00, 0, 8'hAA};
    vt[5] = '{1, 1, 6'd7,  8'h11, 0, 0, 6'd0,  8'h00, 8'h00, 8'h00, 0, 8'h11};
    vt[6] = '{1, 1, 6'd7,  8'h22, 1, 0, 6'd7,  8'h00, 8'h11, 8'h11, 0, 8'h22};
    vt[7] = '{1, 0, 6'd7,  8'h00, 1, 0, 6'd5,  8'h00, 8'h22, 8'hAA, 0, 8'h22};
    vt[8] = '{1, 1, 6'd10, 8'h01, 1, 1, 6'd11, 8'h02, 8'h00, 8'h00, 0, 8'h01};

    reset_n = 1'b0;
    data_a = '0; data_b = '0; addr_a = '0; addr_b = '0;
    idle_ports();
    @(negedge clock);

    // Two reset cycles, then the power-up sweep.
    tick();
    tick();
    chk("rst_q_a", 32'(dqa[0]), 32'h0);
    chk("rst_q_b", 32'(dqb[0]), 32'h0);
    chk("rst_busy_d0", 32'(dbusy[0]), 32'd1);
    chk("rst_busy_d2", 32'(dbusy[2]), 32'd0);
    reset_n = 1'b1;
    count_busy("busy_len_first");
    en_a = 1'b1; addr_a = 6'd0; en_b = 1'b1; addr_b = 6'd31;
    tick();
    chk("clr_rd0", 32'(dqa[0]), 32'h0);
    chk("clr_rd31", 32'(dqb[0]), 32'h0);
    addr_a = 6'd63;
    tick();
    chk("clr_rd63", 32'(dqa[0]), 32'h0);

    // Directed table: cross-port, collision and read-during-write cases.
    for (int i = 0; i < 9; i++) begin
      en_a = vt[i].en_a; we_a = vt[i].we_a; addr_a = vt[i].addr_a; data_a = vt[i].data_a;
      en_b = vt[i].en_b; we_b = vt[i].we_b; addr_b = vt[i].addr_b; data_b = vt[i].data_b;
      tick();
      chk($sformatf("vec%0d_qa", i), 32'(dqa[0]), 32'(vt[i].qa));
      chk($sformatf("vec%0d_qb", i), 32'(dqb[0]), 32'(vt[i].qb));
      chk($sformatf("vec%0d_col", i), 32'(dcol[0]), 32'(vt[i].col));
      chk($sformatf("vec%0d_qa_wf", i), 32'(dqa[1]), 32'(vt[i].qa_wf));
    end
    idle_ports();

    // Seed a word that only the non-clearing instance keeps across reset.
    en_a = 1'b1; we_a = 1'b1; addr_a = 6'd9; data_a = 8'h5A;
    tick();
    idle_ports();

    // Write during busy is ignored; reset at counter 20 restarts the sweep.
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    en_a = 1'b1; we_a = 1'b1; addr_a = 6'd3; data_a = 8'hFF;
    tick();
    chk("busy_wr_q_a", 32'(dqa[0]), 32'h0);
    chk("busy_wr_busy", 32'(dbusy[0]), 32'd1);
    idle_ports();
    repeat (18) tick();
    reset_n = 1'b0;
    tick();
    chk("rerst_busy", 32'(dbusy[0]), 32'd1);
    chk("rerst_busy_d2", 32'(dbusy[2]), 32'd0);
    reset_n = 1'b1;
    count_busy("busy_len_restart");
    en_a = 1'b1; addr_a = 6'd3; en_b = 1'b1; addr_b = 6'd9;
    tick();
    chk("after_clr_rd3", 32'(dqa[0]), 32'h0);
    chk("after_clr_rd9", 32'(dqb[0]), 32'h0);
    chk("noclr_keep9", 32'(dqb[2]), 32'h5A);
    idle_ports();

    // Random traffic on a narrow address window to provoke conflicts.
    for (int c = 0; c < 700; c++) begin
      reset_n = ($urandom_range(0, 149) != 0);
      en_a = $urandom_range(0, 3) != 0;
      we_a = $urandom_range(0, 1) != 0;
      en_b = $urandom_range(0, 3) != 0;
      we_b = $urandom_range(0, 1) != 0;
      addr_a = 6'($urandom_range(0, 7));
      addr_b = 6'($urandom_range(0, 7));
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
